// File: rtl/bip_control_fsm.sv
// -----------------------------------------------------------------------------
// bip_control_fsm
//   Control unit for the BIP accumulator machine. It owns the program counter
//   and a run/halt state machine (IDLE, EXEC, WAIT, HALT). It decodes the
//   instruction at o_pc into the datapath strobes, and it adds jumps and
//   conditional branches. Data-memory reads can be stretched by RD_LATENCY
//   wait cycles.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_instruction  instruction word at o_pc (combinational instruction memory)
//   i_start        single-cycle pulse; leaves IDLE, or restarts from HALT at PC 0
//   i_acc_zero     accumulator == 0 flag, used by BEQ/BNE
//   o_pc           program counter
//   o_data_ins     raw operand field of i_instruction
//   o_sel_a        accumulator input select
//   o_sel_b        ALU B select (0 memory, 1 immediate)
//   o_wr_acc       accumulator write enable
//   o_op_code      ALU op (1 add, 0 sub)
//   o_wr / o_rd    data-memory write / read
//   o_busy         high in EXEC or WAIT
//   o_halted       high in HALT
//   o_illegal      sticky flag: an undefined opcode was fetched
// -----------------------------------------------------------------------------
module bip_control_fsm #(
    parameter int NB_BITS    = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_PC      = 11,
    parameter int RD_LATENCY = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NB_BITS-1:0]           i_instruction,
    input  logic                         i_start,
    input  logic                         i_acc_zero,
    output logic [NB_PC-1:0]             o_pc,
    output logic [NB_BITS-NB_OPCODE-1:0] o_data_ins,
    output logic [1:0]                   o_sel_a,
    output logic                         o_sel_b,
    output logic                         o_wr_acc,
    output logic                         o_op_code,
    output logic                         o_wr,
    output logic                         o_rd,
    output logic                         o_busy,
    output logic                         o_halted,
    output logic                         o_illegal
);

    localparam int NB_OPERAND = NB_BITS - NB_OPCODE;
    localparam int NB_CNT     = 3;   // holds RD_LATENCY up to 7

    localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(RD_LATENCY);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(1);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
    localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(8);
    localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(9);
    localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(10);
    localparam logic [NB_OPCODE-1:0] OP_NOP  = NB_OPCODE'(11);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [NB_PC-1:0]    pc, pc_nxt;
    logic [NB_CNT-1:0]   wait_cnt, wait_cnt_nxt;
    logic                illegal, illegal_nxt;

    logic [NB_OPCODE-1:0]  opcode;
    logic [NB_OPERAND-1:0] operand;
    logic [NB_PC-1:0]      pc_inc;
    logic [NB_PC-1:0]      target;

    logic [1:0] dec_sel_a;
    logic       dec_sel_b;
    logic       dec_wr_acc;
    logic       dec_op_code;
    logic       dec_wr;
    logic       dec_rd;
    logic       dec_legal;
    logic       dec_taken;

    assign opcode  = i_instruction[NB_BITS-1 -: NB_OPCODE];
    assign operand = i_instruction[NB_OPERAND-1:0];
    assign pc_inc  = pc + NB_PC'(1);          // wraps modulo 2^NB_PC
    assign target  = operand[NB_PC-1:0];      // jump targets are truncated

    // Raw opcode decode. The state machine below gates these strobes.
    always_comb begin
        dec_sel_a   = 2'b00;
        dec_sel_b   = 1'b0;
        dec_wr_acc  = 1'b0;
        dec_op_code = 1'b0;
        dec_wr      = 1'b0;
        dec_rd      = 1'b0;
        dec_legal   = 1'b1;
        dec_taken   = 1'b0;
        case (opcode)
            OP_HLT:  begin end
            OP_STO:  begin dec_sel_a = 2'b11; dec_wr = 1'b1; end
            OP_LD:   begin dec_wr_acc = 1'b1; dec_rd = 1'b1; end
            OP_LDI:  begin dec_sel_a = 2'b01; dec_wr_acc = 1'b1; end
            OP_ADD:  begin dec_sel_a = 2'b10; dec_wr_acc = 1'b1; dec_op_code = 1'b1; dec_rd = 1'b1; end
            OP_ADDI: begin dec_sel_a = 2'b10; dec_sel_b = 1'b1; dec_wr_acc = 1'b1; dec_op_code = 1'b1; end
            OP_SUB:  begin dec_sel_a = 2'b10; dec_wr_acc = 1'b1; dec_rd = 1'b1; end
            OP_SUBI: begin dec_sel_a = 2'b10; dec_sel_b = 1'b1; dec_wr_acc = 1'b1; end
            OP_JMP:  dec_taken = 1'b1;
            OP_BEQ:  dec_taken = i_acc_zero;
            OP_BNE:  dec_taken = ~i_acc_zero;
            OP_NOP:  begin end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        wait_cnt_nxt = wait_cnt;
        illegal_nxt  = illegal;
        o_sel_a      = 2'b00;
        o_sel_b      = 1'b0;
        o_wr_acc     = 1'b0;
        o_op_code    = 1'b0;
        o_wr         = 1'b0;
        o_rd         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_sel_a   = dec_sel_a;
                o_sel_b   = dec_sel_b;
                o_wr_acc  = dec_wr_acc;
                o_op_code = dec_op_code;
                o_wr      = dec_wr;
                o_rd      = dec_rd;
                if (!dec_legal) begin
                    illegal_nxt = 1'b1;
                    state_nxt   = ST_HALT;
                end else if (opcode == OP_HLT) begin
                    state_nxt = ST_HALT;
                end else if (dec_rd && (RD_LATENCY != 0)) begin
                    // The accumulator write waits for the last wait cycle,
                    // when the read data is valid.
                    o_wr_acc     = 1'b0;
                    wait_cnt_nxt = CNT_LOAD;
                    state_nxt    = ST_WAIT;
                end else begin
                    pc_nxt = dec_taken ? target : pc_inc;
                end
            end
            ST_WAIT: begin
                // PC is frozen, so the instruction and its selects stay put.
                o_sel_a      = dec_sel_a;
                o_sel_b      = dec_sel_b;
                o_op_code    = dec_op_code;
                o_rd         = 1'b1;
                o_wr_acc     = (wait_cnt == CNT_LAST);
                wait_cnt_nxt = wait_cnt - CNT_LAST;
                if (wait_cnt == CNT_LAST) begin
                    pc_nxt    = pc_inc;
                    state_nxt = ST_EXEC;
                end
            end
            ST_HALT: begin
                if (i_start) begin
                    pc_nxt      = '0;
                    illegal_nxt = 1'b0;
                    state_nxt   = ST_EXEC;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            wait_cnt <= wait_cnt_nxt;
            illegal  <= illegal_nxt;
        end
    end

    assign o_pc       = pc;
    assign o_data_ins = operand;
    assign o_busy     = (state == ST_EXEC) || (state == ST_WAIT);
    assign o_halted   = (state == ST_HALT);
    assign o_illegal  = illegal;

endmodule

// File: tb/tb_bip_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_bip_control_fsm
//   Scoreboard bench for bip_control_fsm. Two instances are used:
//     dut0: NB_PC=11, RD_LATENCY=2
//     dut1: NB_PC=4,  RD_LATENCY=0
//   An instruction-level reference model expands every instruction into the
//   per-cycle outputs it must produce, and queues them. A monitor pops one
//   entry per cycle on the falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_bip_control_fsm;

    typedef struct packed {
        logic [10:0] pc;
        logic [10:0] dins;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        wr_acc;
        logic        op_code;
        logic        wr;
        logic        rd;
        logic        busy;
        logic        halted;
        logic        illegal;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        start [2];
    logic        acc_z [2];
    logic [15:0] mem0 [2048];
    logic [15:0] mem1 [16];

    logic [15:0] instr0, instr1;
    logic [10:0] pc0, dins0, dins1;
    logic [3:0]  pc1;
    logic [1:0]  sel_a0, sel_a1;
    logic        sel_b0, wr_acc0, op0, wr0, rd0, busy0, halted0, ill0;
    logic        sel_b1, wr_acc1, op1, wr1, rd1, busy1, halted1, ill1;

    assign instr0 = mem0[pc0];
    assign instr1 = mem1[pc1];

    bip_control_fsm #(.NB_BITS(16), .NB_OPCODE(5), .NB_PC(11), .RD_LATENCY(2)) dut0 (
        .i_clk(clk), .i_rst(rst_n[0]), .i_instruction(instr0), .i_start(start[0]),
        .i_acc_zero(acc_z[0]), .o_pc(pc0), .o_data_ins(dins0), .o_sel_a(sel_a0),
        .o_sel_b(sel_b0), .o_wr_acc(wr_acc0), .o_op_code(op0), .o_wr(wr0), .o_rd(rd0),
        .o_busy(busy0), .o_halted(halted0), .o_illegal(ill0)
    );

    bip_control_fsm #(.NB_BITS(16), .NB_OPCODE(5), .NB_PC(4), .RD_LATENCY(0)) dut1 (
        .i_clk(clk), .i_rst(rst_n[1]), .i_instruction(instr1), .i_start(start[1]),
        .i_acc_zero(acc_z[1]), .o_pc(pc1), .o_data_ins(dins1), .o_sel_a(sel_a1),
        .o_sel_b(sel_b1), .o_wr_acc(wr_acc1), .o_op_code(op1), .o_wr(wr1), .o_rd(rd1),
        .o_busy(busy1), .o_halted(halted1), .o_illegal(ill1)
    );

    obs_t obs [2];
    assign obs[0] = {pc0, dins0, sel_a0, sel_b0, wr_acc0, op0, wr0, rd0, busy0, halted0, ill0};
    assign obs[1] = {7'd0, pc1, dins1, sel_a1, sel_b1, wr_acc1, op1, wr1, rd1, busy1, halted1, ill1};

    // Architectural model state.
    int m_pc   [2];
    bit m_halt [2];
    bit m_ill  [2];
    bit m_run  [2];

    obs_t q0[$];
    obs_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int pc_mask(input int d);
        return (d == 0) ? 2047 : 15;
    endfunction

    function automatic logic [15:0] fetch(input int d, input int pc);
        if (d == 0) return mem0[pc & 2047];
        return mem1[pc & 15];
    endfunction

    // {sel_a, sel_b, wr_acc, op_code, wr, rd} from the opcode table.
    function automatic logic [6:0] stb(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b11_0_0_0_1_0;
            5'd2:    return 7'b00_0_1_0_0_1;
            5'd3:    return 7'b01_0_1_0_0_0;
            5'd4:    return 7'b10_0_1_1_0_1;
            5'd5:    return 7'b10_1_1_1_0_0;
            5'd6:    return 7'b10_0_1_0_0_1;
            5'd7:    return 7'b10_1_1_0_0_0;
            default: return 7'b00_0_0_0_0_0;
        endcase
    endfunction

    // Outputs while not executing: strobes low, PC and flags from the model.
    function automatic obs_t rec_base(input int d);
        obs_t        r;
        logic [15:0] ins;
        ins       = fetch(d, m_pc[d]);
        r         = '0;
        r.pc      = 11'(m_pc[d]);
        r.dins    = ins[10:0];
        r.halted  = m_halt[d];
        r.illegal = m_ill[d];
        return r;
    endfunction

    task automatic push(input int d, input obs_t r);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic check_obs(input string name, input int d, input obs_t e);
        n_checks++;
        if (obs[d] !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %p, expected %p", name, d, obs[d], e);
        end
    endtask

    task automatic check_v(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: one expected entry per cycle while the model has queued any.
    always @(negedge clk) begin
        if (q0.size() > 0) check_obs("cycle", 0, q0.pop_front());
        if (q1.size() > 0) check_obs("cycle", 1, q1.pop_front());
    end

    // All tasks below start and end at posedge+1.
    task automatic do_reset(input int d);
        #2;
        rst_n[d]  = 1'b0;
        start[d]  = 1'b0;
        m_pc[d]   = 0;
        m_halt[d] = 1'b0;
        m_ill[d]  = 1'b0;
        m_run[d]  = 1'b0;
        #1;
        check_obs("reset_async", d, rec_base(d));
        @(posedge clk); #1;
        check_obs("reset_hold", d, rec_base(d));
        #2;
        rst_n[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    // Sit k cycles in IDLE/HALT, then pulse i_start for one cycle.
    task automatic wait_and_start(input int d, input int k);
        obs_t r;
        start[d] = 1'b0;
        r = rec_base(d);
        for (int i = 0; i < k; i++) push(d, r);
        repeat (k) @(posedge clk);
        #1;
        start[d] = 1'b1;
        push(d, r);
        @(posedge clk); #1;
        start[d] = 1'b0;
        if (m_halt[d]) begin
            m_pc[d]  = 0;
            m_ill[d] = 1'b0;
        end
        m_halt[d] = 1'b0;
        m_run[d]  = 1'b1;
    endtask

    // Execute the instruction at the model PC; i_start is randomly pulsed
    // during execution and must be ignored.
    task automatic exec_instr(input int d, input bit az);
        logic [15:0] ins;
        logic [4:0]  opc;
        int          opd, nxt, n;
        obs_t        r;
        ins      = fetch(d, m_pc[d]);
        opc      = ins[15:11];
        opd      = int'(ins[10:0]);
        acc_z[d] = az;
        start[d] = ($urandom_range(0, 3) == 0);
        r        = rec_base(d);
        r.busy   = 1'b1;
        nxt      = (m_pc[d] + 1) & pc_mask(d);
        n        = 1;
        if (opc >= 5'd1 && opc <= 5'd7) begin
            {r.sel_a, r.sel_b, r.wr_acc, r.op_code, r.wr, r.rd} = stb(opc);
            if (r.rd && lat(d) > 0) begin
                n        = lat(d) + 1;
                r.wr_acc = 1'b0;
            end
        end else if (opc == 5'd8) begin
            nxt = opd & pc_mask(d);
        end else if (opc == 5'd9) begin
            if (az) nxt = opd & pc_mask(d);
        end else if (opc == 5'd10) begin
            if (!az) nxt = opd & pc_mask(d);
        end else if (opc == 5'd0) begin
            nxt       = m_pc[d];
            m_halt[d] = 1'b1;
        end else if (opc != 5'd11) begin
            nxt       = m_pc[d];
            m_halt[d] = 1'b1;
            m_ill[d]  = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            if (n > 1 && k == n - 1) r.wr_acc = 1'b1;
            push(d, r);
        end
        repeat (n) @(posedge clk);
        #1;
        start[d] = 1'b0;
        m_pc[d]  = nxt;
    endtask

    task automatic fill_random(input int d);
        int          sz, pick;
        logic [4:0]  opc;
        logic [15:0] w;
        sz = (d == 0) ? 2048 : 16;
        for (int i = 0; i < sz; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 5)       opc = 5'd0;
            else if (pick < 10) opc = 5'($urandom_range(12, 31));
            else                opc = 5'($urandom_range(1, 11));
            w = {opc, 11'($urandom_range(0, 2047))};
            if (d == 0) mem0[i] = w;
            else        mem1[i] = w;
        end
    endtask

    task automatic run_random(input int d, input int count);
        for (int i = 0; i < count; i++) begin
            if (!m_run[d] || m_halt[d])         wait_and_start(d, $urandom_range(1, 3));
            else if ($urandom_range(0, 39) == 0) do_reset(d);
            else                                 exec_instr(d, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t r;
        for (int i = 0; i < 2048; i++) mem0[i] = 16'h5800;   // NOP
        for (int i = 0; i < 16; i++)   mem1[i] = 16'h5800;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1;
            start[d] = 1'b0;
            acc_z[d] = 1'b0;
            m_run[d] = 1'b0;
        end
        @(posedge clk); #1;

        // ---------------- dut0: NB_PC=11, RD_LATENCY=2 ----------------
        mem0[0] = {5'd3, 11'd5};      // LDI 5
        mem0[1] = {5'd5, 11'd3};      // ADDI 3
        mem0[2] = {5'd0, 11'd0};      // HLT
        do_reset(0);
        wait_and_start(0, 2);
        exec_instr(0, 1'b0);
        exec_instr(0, 1'b0);
        exec_instr(0, 1'b0);
        check_v("prog_halted", 32'(halted0), 32'd1);
        check_v("prog_halt_pc", 32'(pc0), 32'd2);

        mem0[0]     = {5'd2, 11'h010};   // LD 0x010
        mem0[1]     = {5'd9, 11'h040};   // BEQ 0x040 (taken)
        mem0[11'h40] = {5'd9, 11'h050};  // BEQ 0x050 (not taken)
        mem0[11'h41] = {5'd10, 11'h060}; // BNE 0x060 (not taken)
        mem0[11'h42] = {5'd10, 11'h060}; // BNE 0x060 (taken)
        mem0[11'h60] = {5'd8, 11'h7FF};  // JMP 0x7FF
        mem0[11'h7FF] = {5'd11, 11'd0};  // NOP, wraps to 0
        wait_and_start(0, 1);
        check_v("restart_pc", 32'(pc0), 32'd0);
        exec_instr(0, 1'b0);
        check_v("ld_pc_after", 32'(pc0), 32'd1);
        exec_instr(0, 1'b1);
        check_v("beq_taken", 32'(pc0), 32'h040);
        exec_instr(0, 1'b0);
        check_v("beq_not_taken", 32'(pc0), 32'h041);
        exec_instr(0, 1'b1);
        check_v("bne_not_taken", 32'(pc0), 32'h042);
        exec_instr(0, 1'b0);
        check_v("bne_taken", 32'(pc0), 32'h060);
        exec_instr(0, 1'b0);
        check_v("jmp_7ff", 32'(pc0), 32'h7FF);
        exec_instr(0, 1'b0);
        check_v("pc_wrap", 32'(pc0), 32'd0);

        mem0[0] = {5'b11111, 11'h123};   // undefined opcode
        exec_instr(0, 1'b0);
        check_v("illegal_flag", 32'(ill0), 32'd1);
        check_v("illegal_halted", 32'(halted0), 32'd1);
        check_v("illegal_strobes", 32'({sel_a0, sel_b0, wr_acc0, op0, wr0, rd0}), 32'd0);
        wait_and_start(0, 2);
        check_v("illegal_restart", 32'({pc0, ill0, busy0}), 32'({11'd0, 1'b0, 1'b1}));

        // Reset in the middle of a read wait.
        mem0[0] = {5'd2, 11'h010};
        do_reset(0);
        wait_and_start(0, 1);
        r = rec_base(0);
        r.busy = 1'b1;
        {r.sel_a, r.sel_b, r.wr_acc, r.op_code, r.wr, r.rd} = stb(5'd2);
        r.wr_acc = 1'b0;
        push(0, r);
        @(posedge clk); #2;
        check_obs("ld_wait_rd", 0, r);
        rst_n[0] = 1'b0;
        m_pc[0] = 0; m_halt[0] = 1'b0; m_ill[0] = 1'b0; m_run[0] = 1'b0;
        #1;
        check_obs("rst_in_wait", 0, rec_base(0));
        @(posedge clk); #1;
        check_obs("rst_in_wait_hold", 0, rec_base(0));
        #2;
        rst_n[0] = 1'b1;
        @(posedge clk); #1;

        fill_random(0);
        do_reset(0);
        run_random(0, 400);

        // ---------------- dut1: NB_PC=4, RD_LATENCY=0 ----------------
        mem1[0]  = {5'd8, 11'h7F3};   // JMP 0x7F3 -> 3
        mem1[3]  = {5'd8, 11'h00F};   // JMP 15
        mem1[15] = {5'd11, 11'd0};    // NOP, wraps to 0
        do_reset(1);
        wait_and_start(1, 2);
        exec_instr(1, 1'b0);
        check_v("jmp_truncated", 32'(pc1), 32'd3);
        exec_instr(1, 1'b0);
        check_v("jmp_15", 32'(pc1), 32'd15);
        exec_instr(1, 1'b0);
        check_v("pc4_wrap", 32'(pc1), 32'd0);

        fill_random(1);
        do_reset(1);
        run_random(1, 400);

        repeat (2) @(posedge clk);
        check_v("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
